// File: rtl/mem_access_unit_pkg.sv
// Shared encodings for the MEM-stage memory access unit.
// Size codes, FSM states and the default bus timeout.
package mem_access_unit_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam int DEFAULT_TIMEOUT = 16;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RESP
    } state_e;

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering between a 32-bit data bus and sized accesses.
// Produces byte enables, store replication, misalign flag and load extension.
module mem_lane_align
    import mem_access_unit_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    input  logic [31:0] wdata_in,
    input  logic [31:0] rdata_in,
    output logic [3:0]  be,
    output logic [31:0] wdata_out,
    output logic        misalign,
    output logic [31:0] rdata_out
);

    logic [15:0] lane;

    always_comb begin
        be        = 4'b1111;
        wdata_out = wdata_in;
        misalign  = 1'b0;
        rdata_out = rdata_in;
        // Selected lane sits at the bottom after shifting by the byte offset
        lane      = 16'(rdata_in >> {addr_lo, 3'b000});
        unique case (size)
            SZ_BYTE: begin
                be        = 4'b0001 << addr_lo;
                wdata_out = {4{wdata_in[7:0]}};
                rdata_out = {{24{sign_ext & lane[7]}}, lane[7:0]};
            end
            SZ_HALF: begin
                be        = 4'b0011 << addr_lo;
                wdata_out = {2{wdata_in[15:0]}};
                misalign  = addr_lo[0];
                rdata_out = {{16{sign_ext & lane[15]}}, lane[15:0]};
            end
            default: begin
                be        = 4'b1111;
                wdata_out = wdata_in;
                misalign  = |addr_lo;
                rdata_out = rdata_in;
            end
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM stage: drives loads/stores onto a req/gnt/rvalid bus and
// registers the MEM/WB result, stalling upstream while busy.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT,
    parameter int REG_W   = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [31:0]      in_aluout,
    input  logic [31:0]      in_wdata,
    input  logic [REG_W-1:0] in_writereg,
    input  logic             in_regwrite,
    input  logic             in_memread,
    input  logic             in_memwrite,
    input  logic [1:0]       in_size,
    input  logic             in_signed,
    output logic             in_ready,
    output logic             stall,
    output logic             mem_req,
    output logic             mem_we,
    output logic [31:0]      mem_addr,
    output logic [3:0]       mem_be,
    output logic [31:0]      mem_wdata,
    input  logic             mem_gnt,
    input  logic             mem_rvalid,
    input  logic [31:0]      mem_rdata,
    output logic             wb_valid,
    output logic [31:0]      wb_result,
    output logic [REG_W-1:0] wb_writereg,
    output logic             wb_regwrite,
    output logic             misalign_exc,
    output logic             bus_err
);

    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    state_e state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic [31:0]      addr_q, addr_d;
    logic [1:0]       size_q, size_d;
    logic             sign_q, sign_d;
    logic [REG_W-1:0] wreg_q, wreg_d;
    logic             rw_q, rw_d;

    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [3:0]  mem_be_q, mem_be_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;

    logic             wb_valid_q, wb_valid_d;
    logic [31:0]      wb_result_q, wb_result_d;
    logic [REG_W-1:0] wb_writereg_q, wb_writereg_d;
    logic             wb_regwrite_q, wb_regwrite_d;
    logic             misal_q, misal_d;
    logic             berr_q, berr_d;

    logic [1:0]  al_addr;
    logic [1:0]  al_size;
    logic        al_sign;
    logic [3:0]  al_be;
    logic [31:0] al_wdata;
    logic        al_misalign;
    logic [31:0] al_rdata;

    logic is_mem;
    logic timeout_hit;

    // Incoming slot drives the aligner in IDLE; the captured one otherwise
    assign al_addr = (state_q == IDLE) ? in_aluout[1:0] : addr_q[1:0];
    assign al_size = (state_q == IDLE) ? in_size : size_q;
    assign al_sign = (state_q == IDLE) ? in_signed : sign_q;

    mem_lane_align u_align (
        .addr_lo   (al_addr),
        .size      (al_size),
        .sign_ext  (al_sign),
        .wdata_in  (in_wdata),
        .rdata_in  (mem_rdata),
        .be        (al_be),
        .wdata_out (al_wdata),
        .misalign  (al_misalign),
        .rdata_out (al_rdata)
    );

    assign is_mem      = in_memread | in_memwrite;
    assign timeout_hit = (cnt_q == CNT_LAST);

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        addr_d        = addr_q;
        size_d        = size_q;
        sign_d        = sign_q;
        wreg_d        = wreg_q;
        rw_d          = rw_q;
        mem_req_d     = mem_req_q;
        mem_we_d      = mem_we_q;
        mem_addr_d    = mem_addr_q;
        mem_be_d      = mem_be_q;
        mem_wdata_d   = mem_wdata_q;
        wb_valid_d    = 1'b0;
        misal_d       = 1'b0;
        berr_d        = 1'b0;
        wb_result_d   = wb_result_q;
        wb_writereg_d = wb_writereg_q;
        wb_regwrite_d = wb_regwrite_q;

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (!is_mem) begin
                        wb_valid_d    = 1'b1;
                        wb_result_d   = in_aluout;
                        wb_writereg_d = in_writereg;
                        wb_regwrite_d = in_regwrite;
                    end else if (al_misalign) begin
                        wb_valid_d    = 1'b1;
                        misal_d       = 1'b1;
                        wb_result_d   = in_aluout;
                        wb_writereg_d = in_writereg;
                        wb_regwrite_d = 1'b0;
                    end else begin
                        addr_d      = in_aluout;
                        size_d      = in_size;
                        sign_d      = in_signed;
                        wreg_d      = in_writereg;
                        rw_d        = in_regwrite;
                        mem_req_d   = 1'b1;
                        mem_we_d    = in_memwrite;
                        mem_addr_d  = {in_aluout[31:2], 2'b00};
                        mem_be_d    = al_be;
                        mem_wdata_d = al_wdata;
                        cnt_d       = '0;
                        state_d     = REQ;
                    end
                end
            end
            REQ: begin
                if (mem_gnt) begin
                    mem_req_d = 1'b0;
                    cnt_d     = '0;
                    if (mem_we_q) begin
                        wb_valid_d    = 1'b1;
                        wb_result_d   = addr_q;
                        wb_writereg_d = wreg_q;
                        wb_regwrite_d = 1'b0;
                        state_d       = IDLE;
                    end else begin
                        state_d = RESP;
                    end
                end else if (timeout_hit) begin
                    mem_req_d     = 1'b0;
                    wb_valid_d    = 1'b1;
                    berr_d        = 1'b1;
                    wb_result_d   = addr_q;
                    wb_writereg_d = wreg_q;
                    wb_regwrite_d = 1'b0;
                    state_d       = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP: begin
                if (mem_rvalid) begin
                    wb_valid_d    = 1'b1;
                    wb_result_d   = al_rdata;
                    wb_writereg_d = wreg_q;
                    wb_regwrite_d = rw_q;
                    state_d       = IDLE;
                end else if (timeout_hit) begin
                    wb_valid_d    = 1'b1;
                    berr_d        = 1'b1;
                    wb_result_d   = addr_q;
                    wb_writereg_d = wreg_q;
                    wb_regwrite_d = 1'b0;
                    state_d       = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            addr_q        <= '0;
            size_q        <= '0;
            sign_q        <= 1'b0;
            wreg_q        <= '0;
            rw_q          <= 1'b0;
            mem_req_q     <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_be_q      <= '0;
            mem_wdata_q   <= '0;
            wb_valid_q    <= 1'b0;
            wb_result_q   <= '0;
            wb_writereg_q <= '0;
            wb_regwrite_q <= 1'b0;
            misal_q       <= 1'b0;
            berr_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            addr_q        <= addr_d;
            size_q        <= size_d;
            sign_q        <= sign_d;
            wreg_q        <= wreg_d;
            rw_q          <= rw_d;
            mem_req_q     <= mem_req_d;
            mem_we_q      <= mem_we_d;
            mem_addr_q    <= mem_addr_d;
            mem_be_q      <= mem_be_d;
            mem_wdata_q   <= mem_wdata_d;
            wb_valid_q    <= wb_valid_d;
            wb_result_q   <= wb_result_d;
            wb_writereg_q <= wb_writereg_d;
            wb_regwrite_q <= wb_regwrite_d;
            misal_q       <= misal_d;
            berr_q        <= berr_d;
        end
    end

    assign in_ready     = (state_q == IDLE);
    assign stall        = ~in_ready;
    assign mem_req      = mem_req_q;
    assign mem_we       = mem_we_q;
    assign mem_addr     = mem_addr_q;
    assign mem_be       = mem_be_q;
    assign mem_wdata    = mem_wdata_q;
    assign wb_valid     = wb_valid_q;
    assign wb_result    = wb_result_q;
    assign wb_writereg  = wb_writereg_q;
    assign wb_regwrite  = wb_regwrite_q;
    assign misalign_exc = misal_q;
    assign bus_err      = berr_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized bench for mem_access_unit with a transaction-level model.
// Expected WB results are queued per instruction and checked each cycle.
module tb_mem_access_unit;

    localparam int T = 16;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic [31:0] in_aluout;
    logic [31:0] in_wdata;
    logic [4:0]  in_writereg;
    logic        in_regwrite;
    logic        in_memread;
    logic        in_memwrite;
    logic [1:0]  in_size;
    logic        in_signed;
    logic        in_ready;
    logic        stall;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        wb_valid;
    logic [31:0] wb_result;
    logic [4:0]  wb_writereg;
    logic        wb_regwrite;
    logic        misalign_exc;
    logic        bus_err;

    mem_access_unit #(.TIMEOUT(T), .REG_W(5)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_aluout    (in_aluout),
        .in_wdata     (in_wdata),
        .in_writereg  (in_writereg),
        .in_regwrite  (in_regwrite),
        .in_memread   (in_memread),
        .in_memwrite  (in_memwrite),
        .in_size      (in_size),
        .in_signed    (in_signed),
        .in_ready     (in_ready),
        .stall        (stall),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_be       (mem_be),
        .mem_wdata    (mem_wdata),
        .mem_gnt      (mem_gnt),
        .mem_rvalid   (mem_rvalid),
        .mem_rdata    (mem_rdata),
        .wb_valid     (wb_valid),
        .wb_result    (wb_result),
        .wb_writereg  (wb_writereg),
        .wb_regwrite  (wb_regwrite),
        .misalign_exc (misalign_exc),
        .bus_err      (bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] result;
        logic        chk_res;
        logic [4:0]  wreg;
        logic        rw;
        logic        mis;
        logic        berr;
    } exp_t;

    exp_t q[$];

    int n_cmp = 0;
    int n_fail = 0;

    logic        exp_req = 1'b0;
    logic        exp_we = 1'b0;
    logic [31:0] exp_addr = '0;
    logic [3:0]  exp_be = '0;
    logic [31:0] exp_wdata = '0;

    logic [31:0] last_result = '0;
    logic [4:0]  last_wreg = '0;
    logic        last_rw = 1'b0;
    logic        last_mis = 1'b0;
    logic        last_berr = 1'b0;
    logic [3:0]  last_be = '0;
    logic [31:0] last_wdata = '0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    // Model of the sized access rules, in plain arithmetic
    function automatic logic [3:0] m_be(int s, int a);
        int r;
        if (s == 0) r = 1 << a;
        else if (s == 1) r = 3 << a;
        else r = 15;
        return r[3:0];
    endfunction

    function automatic logic [31:0] m_wdata(logic [31:0] d, int s);
        if (s == 0) return (d & 32'hff) * 32'h01010101;
        if (s == 1) return (d & 32'hffff) * 32'h00010001;
        return d;
    endfunction

    function automatic logic m_misal(int s, int a);
        return (s == 1 && (a % 2) != 0) || (s >= 2 && a != 0);
    endfunction

    function automatic logic [31:0] m_load(logic [31:0] d, int s, int a, logic sg);
        longint unsigned v;
        int bits;
        bits = (s == 0) ? 8 : (s == 1) ? 16 : 32;
        v = ({32'd0, d} >> (8 * a)) & ((64'd1 << bits) - 1);
        if (sg && bits < 32 && v >= (64'd1 << (bits - 1)))
            v = v - (64'd1 << bits);
        return v[31:0];
    endfunction

    always @(negedge clk) begin
        chk("stall_vs_ready", stall, !in_ready);
        chk("mem_req", mem_req, exp_req);
        if (exp_req && mem_req) begin
            chk("mem_addr", mem_addr, exp_addr);
            chk("mem_we", mem_we, exp_we);
            chk("mem_be", mem_be, exp_be);
            chk("mem_wdata", mem_wdata, exp_wdata);
            last_be = mem_be;
            last_wdata = mem_wdata;
        end
        if (wb_valid) begin
            last_result = wb_result;
            last_wreg = wb_writereg;
            last_rw = wb_regwrite;
            last_mis = misalign_exc;
            last_berr = bus_err;
            if (q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL spurious_wb: got wb_valid=1 expected 0 at %0t", $time);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("wb_writereg", wb_writereg, e.wreg);
                chk("wb_regwrite", wb_regwrite, e.rw);
                chk("misalign_exc", misalign_exc, e.mis);
                chk("bus_err", bus_err, e.berr);
                if (e.chk_res) chk("wb_result", wb_result, e.result);
            end
        end else begin
            chk("flags_without_wb", {misalign_exc, bus_err}, 0);
        end
    end

    task automatic wb_done(string name);
        n_cmp++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL %s: got %0d pending wb expected 0", name, q.size());
            q.delete();
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Issue one instruction and play the bus side; returns in IDLE
    task automatic do_op(input logic [31:0] addr, input logic [31:0] wd,
                         input logic [4:0] wreg, input logic rw,
                         input logic mr, input logic mw,
                         input logic [1:0] sz, input logic sg,
                         input int gd, input int rd,
                         input logic [31:0] rdat, input logic rvg);
        exp_t e;
        int a;
        int s;
        logic granted;
        a = int'(addr[1:0]);
        s = int'(sz);
        chk("ready_at_issue", in_ready, 1);
        in_valid = 1'b1;
        in_aluout = addr;
        in_wdata = wd;
        in_writereg = wreg;
        in_regwrite = rw;
        in_memread = mr;
        in_memwrite = mw;
        in_size = sz;
        in_signed = sg;
        e = '{result: 32'h0, chk_res: 1'b0, wreg: wreg, rw: 1'b0,
              mis: 1'b0, berr: 1'b0};
        if (!(mr || mw)) begin
            e.result = addr;
            e.chk_res = 1'b1;
            e.rw = rw;
            q.push_back(e);
            tick();
            in_valid = 1'b0;
            chk("alu_no_stall", stall, 0);
            wb_done("alu_latency");
            return;
        end
        if (m_misal(s, a)) begin
            e.mis = 1'b1;
            q.push_back(e);
            tick();
            in_valid = 1'b0;
            wb_done("misal_latency");
            return;
        end
        exp_addr = {addr[31:2], 2'b00};
        exp_we = mw;
        exp_be = m_be(s, a);
        exp_wdata = m_wdata(wd, s);
        exp_req = 1'b1;
        if (mw) begin
            if (gd >= T) e.berr = 1'b1;
        end else if (gd >= T || rd >= T) begin
            e.berr = 1'b1;
        end else begin
            e.result = m_load(rdat, s, a, sg);
            e.chk_res = 1'b1;
            e.rw = rw;
        end
        q.push_back(e);
        tick();
        in_valid = 1'b0;
        granted = 1'b0;
        for (int k = 0; k < T; k++) begin
            chk("stall_req", stall, 1);
            if (k == gd) begin
                mem_gnt = 1'b1;
                if (rvg) begin
                    mem_rvalid = 1'b1;
                    mem_rdata = ~rdat;
                end
                exp_req = 1'b0;
                granted = 1'b1;
                break;
            end
            if (k == T - 1) exp_req = 1'b0;
            else tick();
        end
        tick();
        mem_gnt = 1'b0;
        mem_rvalid = 1'b0;
        if (granted && !mw) begin
            for (int j = 0; j < T; j++) begin
                chk("stall_resp", stall, 1);
                if (j == rd) begin
                    mem_rvalid = 1'b1;
                    mem_rdata = rdat;
                    break;
                end
                if (j < T - 1) tick();
            end
            tick();
            mem_rvalid = 1'b0;
        end
        wb_done("mem_latency");
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        in_valid = 1'b0;
        in_aluout = '0;
        in_wdata = '0;
        in_writereg = '0;
        in_regwrite = 1'b0;
        in_memread = 1'b0;
        in_memwrite = 1'b0;
        in_size = '0;
        in_signed = 1'b0;
        mem_gnt = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata = '0;
        repeat (2) tick();

        chk("rst_in_ready", in_ready, 1);
        chk("rst_stall", stall, 0);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_be", mem_be, 0);
        chk("rst_wb_valid", wb_valid, 0);
        chk("rst_wb_result", wb_result, 0);
        chk("rst_flags", {misalign_exc, bus_err, wb_regwrite}, 0);
        reset = 1'b0;
        tick();

        do_op(32'h1234, 0, 5, 1, 0, 0, 2'b10, 0, 0, 0, 0, 0);
        chk("d_alu_result", last_result, 32'h1234);
        chk("d_alu_wreg", last_wreg, 5);

        do_op(32'h100, 0, 7, 1, 1, 0, 2'b10, 0, 2, 1, 32'hDEADBEEF, 0);
        chk("d_lw_result", last_result, 32'hDEADBEEF);
        chk("d_lw_regwrite", last_rw, 1);

        do_op(32'h103, 0, 3, 1, 1, 0, 2'b00, 1, 0, 0, 32'h80FFFFFF, 1);
        chk("d_lb_be", last_be, 4'b1000);
        chk("d_lb_result", last_result, 32'hFFFFFF80);
        do_op(32'h103, 0, 3, 1, 1, 0, 2'b00, 0, 1, 2, 32'h80FFFFFF, 0);
        chk("d_lbu_result", last_result, 32'h00000080);

        do_op(32'h202, 32'h0000ABCD, 9, 1, 0, 1, 2'b01, 0, 1, 0, 0, 0);
        chk("d_sh_be", last_be, 4'b1100);
        chk("d_sh_wdata", last_wdata, 32'hABCDABCD);
        chk("d_sh_regwrite", last_rw, 0);

        do_op(32'h101, 0, 4, 1, 1, 0, 2'b10, 0, 0, 0, 0, 0);
        chk("d_misal", last_mis, 1);
        chk("d_misal_rw", last_rw, 0);

        do_op(32'h400, 0, 6, 1, 1, 0, 2'b10, 0, T, 0, 0, 0);
        chk("d_berr", last_berr, 1);
        chk("d_berr_rw", last_rw, 0);
        mem_gnt = 1'b1;
        mem_rvalid = 1'b1;
        tick();
        mem_gnt = 1'b0;
        mem_rvalid = 1'b0;
        tick();
        chk("d_late_gnt_ignored", wb_valid, 0);

        do_op(32'h500, 0, 8, 1, 1, 0, 2'b01, 1, 0, T, 0, 0);
        chk("d_resp_berr", last_berr, 1);

        // Abandon a load in RESP with reset, then deliver its data late
        in_valid = 1'b1;
        in_aluout = 32'h300;
        in_memread = 1'b1;
        in_memwrite = 1'b0;
        in_size = 2'b10;
        in_regwrite = 1'b1;
        exp_addr = 32'h300;
        exp_we = 1'b0;
        exp_be = 4'b1111;
        exp_wdata = in_wdata;
        exp_req = 1'b1;
        tick();
        in_valid = 1'b0;
        mem_gnt = 1'b1;
        exp_req = 1'b0;
        tick();
        mem_gnt = 1'b0;
        chk("r_in_resp_stall", stall, 1);
        reset = 1'b1;
        #1;
        chk("r_mem_req_async", mem_req, 0);
        chk("r_wb_valid_async", wb_valid, 0);
        chk("r_ready_async", in_ready, 1);
        tick();
        reset = 1'b0;
        tick();
        mem_rvalid = 1'b1;
        mem_rdata = 32'h12345678;
        tick();
        mem_rvalid = 1'b0;
        tick();
        chk("r_late_rvalid", wb_valid, 0);

        for (int i = 0; i < 200; i++) begin
            logic [31:0] ad;
            logic mr;
            logic mw;
            int kind;
            int gd;
            int rd;
            ad = $urandom;
            if ($urandom_range(0, 1) == 0) ad[1:0] = 2'b00;
            kind = $urandom_range(0, 9);
            mr = 1'b0;
            mw = 1'b0;
            if (kind >= 4) begin
                case ($urandom_range(0, 2))
                    0: mr = 1'b1;
                    1: mw = 1'b1;
                    default: begin mr = 1'b1; mw = 1'b1; end
                endcase
            end
            gd = ($urandom_range(0, 19) == 0) ? T + $urandom_range(0, 2)
                                               : $urandom_range(0, 4);
            rd = ($urandom_range(0, 19) == 0) ? T + $urandom_range(0, 2)
                                               : $urandom_range(0, 4);
            do_op(ad, $urandom, 5'($urandom_range(0, 31)),
                  1'($urandom_range(0, 1)), mr, mw,
                  2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  gd, rd, $urandom, 1'($urandom_range(0, 3) == 0));
            if ($urandom_range(0, 4) == 0)
                repeat ($urandom_range(1, 3)) tick();
        end

        repeat (3) tick();
        wb_done("final_drain");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
